// File: rtl/resonator_dds_cmul_rnd.sv
// -----------------------------------------------------------------------------
// resonator_dds_cmul_rnd
//   Pipelined complex multiplier P = A * B with selectable rounding, arithmetic
//   right shift, output saturation and overflow reporting.
//
//   Pipeline (each stage advances only when ce = 1):
//     1  input registers
//     2  four partial products
//     3  real difference / imaginary sum (full precision, A_WIDTH+B_WIDTH+1)
//     4  rounding add (one extra guard bit) + arithmetic shift by SHIFT
//     5  saturation to OUT_WIDTH, overflow flag, output register
//     6..LATENCY  pure delay of the stage-5 results
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   ce          clock enable for every pipeline register
//   in_valid    qualifies a_re/a_im/b_re/b_im
//   a_re, a_im  signed operand A (A_WIDTH each)
//   b_re, b_im  signed operand B (B_WIDTH each)
//   clr_ovf     clears ovf_sticky (acts even when ce = 0)
//   out_valid   qualifies p_re/p_im/ovf
//   p_re, p_im  rounded, saturated product (OUT_WIDTH each)
//   ovf         either component of the current output clipped
//   ovf_sticky  OR of all ovf pulses since the last clear
//
// ROUND_MODE: 0 = floor, 1 = round half up, 2 = round half to even.
// SHIFT = 0 passes the full-precision value straight to saturation.
// -----------------------------------------------------------------------------
module resonator_dds_cmul_rnd #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND_MODE = 1,
  parameter int LATENCY    = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic signed [A_WIDTH-1:0]   a_re,
  input  logic signed [A_WIDTH-1:0]   a_im,
  input  logic signed [B_WIDTH-1:0]   b_re,
  input  logic signed [B_WIDTH-1:0]   b_im,
  input  logic                        clr_ovf,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] p_re,
  output logic signed [OUT_WIDTH-1:0] p_im,
  output logic                        ovf,
  output logic                        ovf_sticky
);

  localparam int PW = A_WIDTH + B_WIDTH;                           // one product
  localparam int FW = PW + 1;                                      // sum of two products
  localparam int RW = FW + 1;                                      // rounding adder
  localparam int SW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;     // saturation compare
  localparam int ND = LATENCY - 4;                                 // stage 5 + delay stages

  localparam logic signed [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};
  // Discarded-bit mask and the half-LSB weight; both collapse to 0 for SHIFT = 0.
  localparam logic signed [RW-1:0] MASK = (ONE << SHIFT) - ONE;
  localparam logic signed [RW-1:0] HALF = (ONE << SHIFT) >> 1;

  localparam logic signed [SW-1:0] SONE    = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SAT_MAX = (SONE << (OUT_WIDTH-1)) - SONE;
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef struct packed {
    logic                        clip;
    logic signed [OUT_WIDTH-1:0] val;
  } sat_t;

  // Rounding add + arithmetic shift. The add runs one bit wider than the
  // full-precision value so it can never wrap.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [FW-1:0] x);
    logic signed [RW-1:0] xw;
    logic signed [RW-1:0] addend;
    xw     = RW'(x);
    addend = '0;
    if (SHIFT != 0) begin
      if (ROUND_MODE == 1) begin
        addend = HALF;
      end else if (ROUND_MODE == 2) begin
        // Exact tie with an even retained LSB: stop just short of the carry.
        if (((xw & MASK) == HALF) && !xw[SHIFT]) addend = HALF - ONE;
        else                                      addend = HALF;
      end
    end
    return (xw + addend) >>> SHIFT;
  endfunction

  function automatic sat_t saturate(input logic signed [RW-1:0] z);
    sat_t                 r;
    logic signed [SW-1:0] zs;
    zs = SW'(z);
    if (zs > SAT_MAX) begin
      r.clip = 1'b1;
      r.val  = OUT_WIDTH'(SAT_MAX);
    end else if (zs < SAT_MIN) begin
      r.clip = 1'b1;
      r.val  = OUT_WIDTH'(SAT_MIN);
    end else begin
      r.clip = 1'b0;
      r.val  = OUT_WIDTH'(zs);
    end
    return r;
  endfunction

  // Valid shift register: vld[n-1] travels with the data held in stage n.
  logic [LATENCY-1:0] vld;

  logic signed [A_WIDTH-1:0] s1_a_re, s1_a_im;
  logic signed [B_WIDTH-1:0] s1_b_re, s1_b_im;
  logic signed [PW-1:0]      pp_rr, pp_ii, pp_ri, pp_ir;
  logic signed [FW-1:0]      s3_re, s3_im;
  logic signed [RW-1:0]      s4_re, s4_im;

  logic signed [OUT_WIDTH-1:0] q_re  [ND];
  logic signed [OUT_WIDTH-1:0] q_im  [ND];
  logic                        q_ovf [ND];

  sat_t sat_re, sat_im;

  assign sat_re = saturate(s4_re);
  assign sat_im = saturate(s4_im);

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld     <= '0;
      s1_a_re <= '0;
      s1_a_im <= '0;
      s1_b_re <= '0;
      s1_b_im <= '0;
      pp_rr   <= '0;
      pp_ii   <= '0;
      pp_ri   <= '0;
      pp_ir   <= '0;
      s3_re   <= '0;
      s3_im   <= '0;
      s4_re   <= '0;
      s4_im   <= '0;
    end else if (ce) begin
      vld     <= {vld[LATENCY-2:0], in_valid};
      s1_a_re <= a_re;
      s1_a_im <= a_im;
      s1_b_re <= b_re;
      s1_b_im <= b_im;
      pp_rr   <= PW'(s1_a_re) * PW'(s1_b_re);
      pp_ii   <= PW'(s1_a_im) * PW'(s1_b_im);
      pp_ri   <= PW'(s1_a_re) * PW'(s1_b_im);
      pp_ir   <= PW'(s1_a_im) * PW'(s1_b_re);
      s3_re   <= FW'(pp_rr) - FW'(pp_ii);
      s3_im   <= FW'(pp_ri) + FW'(pp_ir);
      s4_re   <= round_shift(s3_re);
      s4_im   <= round_shift(s3_im);
    end
  end

  // Stage 5 and the trailing delay stages.
  // NOTE: the delay line is a small register array, not a RAM, so each entry
  // is cleared on reset like any other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ND; i++) begin
        q_re[i]  <= '0;
        q_im[i]  <= '0;
        q_ovf[i] <= 1'b0;
      end
    end else if (ce) begin
      q_re[0]  <= sat_re.val;
      q_im[0]  <= sat_im.val;
      // Overflow only counts for a real sample (stage-4 valid).
      q_ovf[0] <= (sat_re.clip | sat_im.clip) & vld[3];
      for (int i = 1; i < ND; i++) begin
        q_re[i]  <= q_re[i-1];
        q_im[i]  <= q_im[i-1];
        q_ovf[i] <= q_ovf[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign p_re      = q_re[ND-1];
  assign p_im      = q_im[ND-1];
  assign ovf       = q_ovf[ND-1];

  // Set (observed overflow while advancing) has priority over clear; the
  // clear itself does not wait for ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      ovf_sticky <= 1'b0;
    else if (ce && out_valid && ovf)   ovf_sticky <= 1'b1;
    else if (clr_ovf)                  ovf_sticky <= 1'b0;
  end

endmodule
